mem_load_queue: RTL

//  Parametrised memory stage. Holds up to DEPTH in-flight instructions between EXE and WB.

---
 rtl/mem_load_queue_pkg.sv | 19 +
 rtl/mem_load_queue_if.sv | 42 ++++
 rtl/mem_load_queue_ld_align.sv | 48 ++++
 rtl/mem_load_queue.sv | 134 +++++++++++++
 4 files changed

// File: rtl/mem_load_queue_pkg.sv
// Load-op encodings shared with the decoder/EXE stage, plus small helpers.
package mem_load_queue_pkg;

    typedef enum logic [2:0] {
        LDOP_NONE = 3'd0,
        LDOP_LB   = 3'd1,
        LDOP_LBU  = 3'd2,
        LDOP_LH   = 3'd3,
        LDOP_LHU  = 3'd4,
        LDOP_LW   = 3'd5,
        LDOP_LWL  = 3'd6,
        LDOP_LWR  = 3'd7
    } ldop_e;

    function automatic logic is_load(input ldop_e op);
        return op != LDOP_NONE;
    endfunction

endpackage

// File: rtl/mem_load_queue_if.sv
// EXE-side, SRAM-response and WB-side signals of the memory stage.
interface mem_load_queue_if
    import mem_load_queue_pkg::*;
#(
    parameter int DEST_W = 5,
    parameter int SIDE_W = 8
);
    logic              exe_valid;
    logic              exe_ready;
    ldop_e             exe_ldop;
    logic [1:0]        exe_addr_lo;
    logic [DEST_W-1:0] exe_dest;
    logic [31:0]       exe_value;
    logic [31:0]       exe_rt_value;
    logic [SIDE_W-1:0] exe_side;
    logic [31:0]       exe_pc;
    logic [31:0]       exe_inst;
    logic              data_rvalid;
    logic [31:0]       data_rdata;
    logic              flush;
    logic              wb_valid;
    logic              wb_ready;
    logic [DEST_W-1:0] wb_dest;
    logic [31:0]       wb_value;
    logic [SIDE_W-1:0] wb_side;
    logic [31:0]       wb_pc;
    logic [31:0]       wb_inst;
    logic              resp_err;

    modport master (
        output exe_valid, exe_ldop, exe_addr_lo, exe_dest, exe_value, exe_rt_value,
               exe_side, exe_pc, exe_inst, data_rvalid, data_rdata, flush, wb_ready,
        input  exe_ready, wb_valid, wb_dest, wb_value, wb_side, wb_pc, wb_inst, resp_err
    );

    modport slave (
        input  exe_valid, exe_ldop, exe_addr_lo, exe_dest, exe_value, exe_rt_value,
               exe_side, exe_pc, exe_inst, data_rvalid, data_rdata, flush, wb_ready,
        output exe_ready, wb_valid, wb_dest, wb_value, wb_side, wb_pc, wb_inst, resp_err
    );

endinterface

// File: rtl/mem_load_queue_ld_align.sv
// Load data alignment, sign/zero extension and LWL/LWR merge with the old rt value.
// Latency: combinational.
// Backpressure: none.
module mem_load_queue_ld_align
    import mem_load_queue_pkg::*;
(
    input  ldop_e       i_ldop,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_rt_value,
    input  logic [31:0] i_value,
    output logic [31:0] o_result
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_result = i_value;
        case (i_ldop)
            LDOP_LB:  o_result = {{24{w_byte[7]}}, w_byte};
            LDOP_LBU: o_result = {24'd0, w_byte};
            LDOP_LH:  o_result = {{16{w_half[15]}}, w_half};
            LDOP_LHU: o_result = {16'd0, w_half};
            LDOP_LW:  o_result = i_rdata;
            LDOP_LWL: begin
                case (i_addr_lo)
                    2'd0:    o_result = {i_rdata[7:0],  i_rt_value[23:0]};
                    2'd1:    o_result = {i_rdata[15:0], i_rt_value[15:0]};
                    2'd2:    o_result = {i_rdata[23:0], i_rt_value[7:0]};
                    default: o_result = i_rdata;
                endcase
            end
            LDOP_LWR: begin
                case (i_addr_lo)
                    2'd0:    o_result = i_rdata;
                    2'd1:    o_result = {i_rt_value[31:24], i_rdata[31:8]};
                    2'd2:    o_result = {i_rt_value[31:16], i_rdata[31:16]};
                    default: o_result = {i_rt_value[31:8],  i_rdata[31:24]};
                endcase
            end
            default:  o_result = i_value;
        endcase
    end

endmodule

// File: rtl/mem_load_queue.sv
// In-order memory-stage queue between EXE and WB; loads complete from in-order SRAM responses.
// Latency: head entry visible to WB the cycle after enqueue (non-load) or after its response.
// Backpressure: exe_ready drops when queued entries plus responses still to discard reach DEPTH.
module mem_load_queue
    import mem_load_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DEST_W = 5,
    parameter int SIDE_W = 8,
    parameter int DEBUG  = 1
) (
    input logic             clk,
    input logic             resetn,
    mem_load_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    ldop_e             r_ldop    [DEPTH];
    logic [1:0]        r_addr_lo [DEPTH];
    logic [DEST_W-1:0] r_dest    [DEPTH];
    logic [31:0]       r_value   [DEPTH];
    logic [31:0]       r_rt      [DEPTH];
    logic [31:0]       r_data    [DEPTH];
    logic [31:0]       r_pc      [DEPTH];
    logic [31:0]       r_inst    [DEPTH];
    logic [SIDE_W-1:0] r_side    [DEPTH];
    logic [DEPTH-1:0]  r_done;
    logic [PTR_W-1:0]  r_lif     [DEPTH];

    logic [PTR_W-1:0] r_head, r_tail, r_lif_head, r_lif_tail;
    logic [CNT_W-1:0] r_count, r_lif_cnt, r_discard_cnt;
    logic             r_resp_err;

    logic             w_head_vld, w_enq, w_deq, w_lif_push;
    logic             w_resp_drop, w_resp_to_lif, w_resp_orphan;
    logic [CNT_W:0]   w_occ;
    logic [PTR_W-1:0] w_lif_tgt;
    logic [31:0]      w_aligned;

    assign w_occ         = {1'b0, r_count} + {1'b0, r_discard_cnt};
    assign bus.exe_ready = w_occ < DEPTH_C;
    assign w_head_vld    = (r_count != '0) && r_done[r_head];

    assign w_enq      = bus.exe_valid && bus.exe_ready && !bus.flush;
    assign w_deq      = w_head_vld && bus.wb_ready && !bus.flush;
    assign w_lif_push = w_enq && is_load(bus.exe_ldop);
    assign w_lif_tgt  = r_lif[r_lif_head];

    // Responses belong to flushed loads first, then to the oldest waiting load.
    assign w_resp_drop   = bus.data_rvalid && (r_discard_cnt != '0);
    assign w_resp_to_lif = bus.data_rvalid && (r_discard_cnt == '0) && (r_lif_cnt != '0);
    assign w_resp_orphan = bus.data_rvalid && (r_discard_cnt == '0) && (r_lif_cnt == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_lif_head    <= '0;
            r_lif_tail    <= '0;
            r_lif_cnt     <= '0;
            r_discard_cnt <= '0;
            r_resp_err    <= 1'b0;
        end else begin
            if (w_resp_orphan)
                r_resp_err <= 1'b1;
            if (bus.flush) begin
                r_head        <= '0;
                r_tail        <= '0;
                r_count       <= '0;
                r_lif_head    <= '0;
                r_lif_tail    <= '0;
                r_lif_cnt     <= '0;
                // Every load still waiting owes one response that must now be thrown away.
                r_discard_cnt <= r_discard_cnt - CNT_W'(w_resp_drop)
                               + r_lif_cnt - CNT_W'(w_resp_to_lif);
            end else begin
                if (w_enq)
                    r_tail <= r_tail + PTR_W'(1);
                if (w_deq)
                    r_head <= r_head + PTR_W'(1);
                r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
                if (w_lif_push)
                    r_lif_tail <= r_lif_tail + PTR_W'(1);
                if (w_resp_to_lif)
                    r_lif_head <= r_lif_head + PTR_W'(1);
                r_lif_cnt <= r_lif_cnt + CNT_W'(w_lif_push) - CNT_W'(w_resp_to_lif);
                if (w_resp_drop)
                    r_discard_cnt <= r_discard_cnt - CNT_W'(1);
            end
        end
    end

    // Payload storage; validity is tracked entirely by the pointers and counters above.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_ldop[r_tail]    <= bus.exe_ldop;
            r_addr_lo[r_tail] <= bus.exe_addr_lo;
            r_dest[r_tail]    <= bus.exe_dest;
            r_value[r_tail]   <= bus.exe_value;
            r_rt[r_tail]      <= bus.exe_rt_value;
            r_side[r_tail]    <= bus.exe_side;
            r_pc[r_tail]      <= (DEBUG != 0) ? bus.exe_pc   : 32'd0;
            r_inst[r_tail]    <= (DEBUG != 0) ? bus.exe_inst : 32'd0;
            r_done[r_tail]    <= !is_load(bus.exe_ldop);
        end
        if (w_lif_push)
            r_lif[r_lif_tail] <= r_tail;
        if (w_resp_to_lif) begin
            r_data[w_lif_tgt] <= bus.data_rdata;
            r_done[w_lif_tgt] <= 1'b1;
        end
    end

    mem_load_queue_ld_align u_ld_align (
        .i_ldop     (r_ldop[r_head]),
        .i_addr_lo  (r_addr_lo[r_head]),
        .i_rdata    (r_data[r_head]),
        .i_rt_value (r_rt[r_head]),
        .i_value    (r_value[r_head]),
        .o_result   (w_aligned)
    );

    assign bus.wb_valid = w_head_vld;
    assign bus.wb_dest  = w_head_vld ? r_dest[r_head] : '0;
    assign bus.wb_value = w_head_vld ? w_aligned      : '0;
    assign bus.wb_side  = w_head_vld ? r_side[r_head] : '0;
    assign bus.wb_pc    = w_head_vld ? r_pc[r_head]   : '0;
    assign bus.wb_inst  = w_head_vld ? r_inst[r_head] : '0;
    assign bus.resp_err = r_resp_err;

endmodule
